// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with architectural HI/LO.
// Sits beside the ALU in EXE. Executes MULT, MULTU, DIV, DIVU through an
// IDLE -> CALC (ITER cycles) -> ADJUST flow and MTHI/MTLO in a single cycle.
// HI/LO can be read at any time; stall holds a colliding EXE instruction.
//
// Ports:
//   clk          main clock
//   rst          synchronous reset, active-high (overrides cancel and start)
//   start        request from the EXE-stage instruction, qualified by op
//   op           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//   opa / opb    rs / rt operands
//   read_hilo    EXE-stage instruction is MFHI/MFLO
//   cancel       flush: abort the operation in flight
//   busy         state != IDLE
//   stall        busy & (start | read_hilo), combinational
//   done         one-cycle pulse; hi/lo already hold the new result
//   div_by_zero  pulses with done when a DIV/DIVU had opb == 0
//   hi / lo      architectural HI and LO registers
module muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             read_hilo,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 2 * WIDTH;

  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_width_check
    $error("muldiv_unit: WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_ADJUST = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  // Multiply: [2W:W] partial sum, [W-1:0] multiplier bits still to consume.
  // Divide:   [2W:W] partial remainder, [W-1:0] dividend bits / quotient.
  logic [PW:0]      acc_r;
  logic [WIDTH-1:0] opnd_r;   // multiplicand (mul) or divisor (div)
  logic             is_div_r;
  logic             neg_q_r;  // negate product / quotient
  logic             neg_r_r;  // negate remainder (dividend was negative)
  logic             dz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic             dbz_r;

  logic             signed_op_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [PW:0]      step_s;
  logic [PW-1:0]    prod_s;
  logic [WIDTH-1:0] res_hi_s;
  logic [WIDTH-1:0] res_lo_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Operand sign detection and magnitude capture for the start decode.
  always_comb begin
    signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    a_neg_s     = signed_op_s & opa[WIDTH-1];
    b_neg_s     = signed_op_s & opb[WIDTH-1];
    mag_a_s     = a_neg_s ? neg_w(opa) : opa;
    mag_b_s     = b_neg_s ? neg_w(opb) : opb;
  end

  // One CALC iteration: BITS_PER_CYCLE shift-add or restoring-divide steps.
  always_comb begin
    step_s = acc_r;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (is_div_r) begin
        step_s = {step_s[PW-1:0], 1'b0};
        if (step_s[PW:WIDTH] >= {1'b0, opnd_r}) begin
          step_s[PW:WIDTH] = step_s[PW:WIDTH] - {1'b0, opnd_r};
          step_s[0]        = 1'b1;
        end else begin
          step_s[0] = 1'b0;
        end
      end else begin
        // Top bit is always clear here, so the W+1-bit sum cannot overflow.
        if (step_s[0]) begin
          step_s[PW:WIDTH] = {1'b0, step_s[PW-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
          step_s[PW:WIDTH] = {1'b0, step_s[PW-1:WIDTH]};
        end
        step_s = {1'b0, step_s[PW:1]};
      end
    end
  end

  // Sign correction of the unsigned result written during ADJUST.
  always_comb begin
    prod_s = neg_q_r ? (~acc_r[PW-1:0] + PW'(1)) : acc_r[PW-1:0];
    if (is_div_r) begin
      // Zero divisor: remainder is |opa|, so restoring its sign returns opa.
      res_hi_s = neg_r_r ? neg_w(acc_r[PW-1:WIDTH]) : acc_r[PW-1:WIDTH];
      if (dz_r) begin
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_lo_s = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      end
    end else begin
      res_hi_s = prod_s[PW-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(PW+1){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc_r    <= {{(WIDTH+1){1'b0}}, mag_b_s};
                opnd_r   <= mag_a_s;
                is_div_r <= 1'b0;
                neg_q_r  <= a_neg_s ^ b_neg_s;
                neg_r_r  <= 1'b0;
                dz_r     <= 1'b0;
                cnt_r    <= CW'(ITER);
                state_r  <= S_CALC;
              end
              OP_DIV, OP_DIVU: begin
                acc_r    <= {{(WIDTH+1){1'b0}}, mag_a_s};
                opnd_r   <= mag_b_s;
                is_div_r <= 1'b1;
                neg_q_r  <= a_neg_s ^ b_neg_s;
                neg_r_r  <= a_neg_s;
                dz_r     <= (opb == {WIDTH{1'b0}});
                cnt_r    <= CW'(ITER);
                state_r  <= S_CALC;
              end
              OP_MTHI: hi_r <= opa;
              OP_MTLO: lo_r <= opa;
              default: state_r <= S_IDLE;
            endcase
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state_r <= S_IDLE;
          end else begin
            acc_r   <= step_s;
            cnt_r   <= cnt_r - CW'(1);
            state_r <= (cnt_r == CW'(1)) ? S_ADJUST : S_CALC;
          end
        end
        S_ADJUST: begin
          if (cancel) begin
            state_r <= S_IDLE;
          end else begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            done_r  <= 1'b1;
            dbz_r   <= dz_r;
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_r != S_IDLE);
  assign stall       = busy & (start | read_hilo);
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: a 32-bit/1-bit-per-cycle instance and
// a 16-bit/4-bits-per-cycle instance, with hand-computed expected values.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // 32-bit instance
  logic        start32, read32, cancel32;
  logic [2:0]  op32;
  logic [31:0] opa32, opb32;
  logic        busy32, stall32, done32, dbz32;
  logic [31:0] hi32, lo32;
  // 16-bit instance
  logic        start16;
  logic [2:0]  op16;
  logic [15:0] opa16, opb16;
  logic        busy16, stall16, done16, dbz16;
  logic [15:0] hi16, lo16;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .opa(opa32), .opb(opb32),
    .read_hilo(read32), .cancel(cancel32), .busy(busy32), .stall(stall32),
    .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .opa(opa16), .opb(opb16),
    .read_hilo(1'b0), .cancel(1'b0), .busy(busy16), .stall(stall16),
    .done(done16), .div_by_zero(dbz16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge.
  task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = o; opa32 = a; opb32 = b;
    tick();
    start32 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; op16 = o; opa16 = a; opb16 = b;
    tick();
    start16 = 1'b0;
  endtask

  // Edges from the start edge until done, and busy cycles seen meanwhile.
  task automatic wait32(output int edges, output int bcnt);
    edges = 0; bcnt = 0;
    while (done32 !== 1'b1 && edges < 100) begin
      if (busy32 === 1'b1) bcnt++;
      tick();
      edges++;
    end
  endtask

  task automatic wait16(output int edges);
    edges = 0;
    while (done16 !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  int          lat, bcnt, scnt, dcnt;
  logic [15:0] va[7];
  logic [15:0] vb[7];
  logic [15:0] exp_q, exp_r;

  initial begin
    rst = 1'b1;
    start32 = 1'b0; read32 = 1'b0; cancel32 = 1'b0; op32 = 3'd0; opa32 = 32'd0; opb32 = 32'd0;
    start16 = 1'b0; op16 = 3'd0; opa16 = 16'd0; opb16 = 16'd0;
    tick(); tick();
    check("rst_hi", 64'(hi32), 64'h0);
    check("rst_lo", 64'(lo32), 64'h0);
    check("rst_busy", 64'(busy32), 64'h0);
    check("rst_done", 64'(done32), 64'h0);
    check("rst_dbz", 64'(dbz32), 64'h0);
    rst = 1'b0;
    tick();

    // MULT -3 * 7
    issue32(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy_after_start", 64'(busy32), 64'h1);
    wait32(lat, bcnt);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_busy_cycles", 64'(bcnt), 64'd33);
    check("mult_busy_in_done", 64'(busy32), 64'h0);
    check("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo32), 64'hFFFF_FFEB);
    check("mult_dbz", 64'(dbz32), 64'h0);
    tick();
    check("done_one_pulse", 64'(done32), 64'h0);

    // MULTU max * max
    issue32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32(lat, bcnt);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_hi", 64'(hi32), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo32), 64'h0000_0001);
    tick();

    // MTLO / MTHI in IDLE
    issue32(3'd5, 32'h0000_1234, 32'd0);
    check("mtlo_lo", 64'(lo32), 64'h1234);
    check("mtlo_hi_kept", 64'(hi32), 64'hFFFF_FFFE);
    check("mtlo_busy", 64'(busy32), 64'h0);
    tick();
    check("mtlo_no_done", 64'(done32), 64'h0);
    issue32(3'd4, 32'h0000_CAFE, 32'd0);
    check("mthi_hi", 64'(hi32), 64'hCAFE);
    check("mthi_busy", 64'(busy32), 64'h0);

    // DIV -7 / 2
    issue32(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait32(lat, bcnt);
    check("div_latency", 64'(lat), 64'd33);
    check("div_lo", 64'(lo32), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi32), 64'hFFFF_FFFF);
    check("div_dbz", 64'(dbz32), 64'h0);
    tick();

    // DIVU 7 / 0
    issue32(3'd3, 32'd7, 32'd0);
    wait32(lat, bcnt);
    check("divu0_latency", 64'(lat), 64'd33);
    check("divu0_lo", 64'(lo32), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(hi32), 64'h7);
    check("divu0_dbz", 64'(dbz32), 64'h1);
    tick();
    check("dbz_one_pulse", 64'(dbz32), 64'h0);

    // DIV most-negative / -1
    issue32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait32(lat, bcnt);
    check("divovf_lo", 64'(lo32), 64'h8000_0000);
    check("divovf_hi", 64'(hi32), 64'h0);
    check("divovf_dbz", 64'(dbz32), 64'h0);
    tick();

    // DIV -5 / 0 (signed divide by zero)
    issue32(3'd2, 32'hFFFF_FFFB, 32'd0);
    wait32(lat, bcnt);
    check("div0_lo", 64'(lo32), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi32), 64'hFFFF_FFFB);
    check("div0_dbz", 64'(dbz32), 64'h1);
    tick();

    // DIVU 100/7 cancelled in the 5th CALC cycle
    issue32(3'd3, 32'd100, 32'd7);
    tick(); tick(); tick(); tick();
    check("cancel_busy_before", 64'(busy32), 64'h1);
    cancel32 = 1'b1;
    tick();
    cancel32 = 1'b0;
    check("cancel_busy", 64'(busy32), 64'h0);
    check("cancel_hi_kept", 64'(hi32), 64'hFFFF_FFFB);
    check("cancel_lo_kept", 64'(lo32), 64'hFFFF_FFFF);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32 === 1'b1) dcnt++;
      tick();
    end
    check("cancel_no_done", 64'(dcnt), 64'd0);

    // cancel in IDLE suppresses a coincident MTLO
    cancel32 = 1'b1;
    issue32(3'd5, 32'h0000_DEAD, 32'd0);
    cancel32 = 1'b0;
    check("cancel_idle_lo", 64'(lo32), 64'hFFFF_FFFF);
    check("cancel_idle_busy", 64'(busy32), 64'h0);

    // reserved op does nothing
    issue32(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("rsvd_busy", 64'(busy32), 64'h0);
    check("rsvd_hi", 64'(hi32), 64'hFFFF_FFFB);
    check("rsvd_lo", 64'(lo32), 64'hFFFF_FFFF);

    // MULT 5*6 in flight, MFHI/MFLO and a second MULT 3*4 held behind it
    issue32(3'd0, 32'd5, 32'd6);
    read32 = 1'b1;
    start32 = 1'b1; op32 = 3'd0; opa32 = 32'd3; opb32 = 32'd4;
    #1;
    lat = 0; scnt = 0;
    while (done32 !== 1'b1 && lat < 100) begin
      if (stall32 === 1'b1) scnt++;
      tick();
      lat++;
    end
    check("stall_latency", 64'(lat), 64'd33);
    check("stall_cycles", 64'(scnt), 64'd33);
    check("stall_in_done", 64'(stall32), 64'h0);
    check("stall_done_hi", 64'(hi32), 64'h0);
    check("stall_done_lo", 64'(lo32), 64'd30);
    tick();
    start32 = 1'b0;
    read32 = 1'b0;
    check("b2b_accepted", 64'(busy32), 64'h1);
    wait32(lat, bcnt);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_lo", 64'(lo32), 64'd12);
    check("b2b_hi", 64'(hi32), 64'h0);
    tick();

    // 16-bit, 4 bits per cycle: MULT 0x8000 * 0x8000
    issue16(3'd0, 16'h8000, 16'h8000);
    check("m16_busy", 64'(busy16), 64'h1);
    wait16(lat);
    check("m16_latency", 64'(lat), 64'd5);
    check("m16_hi", 64'(hi16), 64'h4000);
    check("m16_lo", 64'(lo16), 64'h0000);
    tick();

    // 16-bit DIVU sweep against the / and % reference
    va = '{16'd100, 16'hFFFF, 16'hFFFF, 16'h1234, 16'd7, 16'hABCD, 16'h8000};
    vb = '{16'd7,   16'd1,    16'hFFFF, 16'd0,    16'd100, 16'h0012, 16'd3};
    for (int i = 0; i < 7; i++) begin
      if (vb[i] == 16'd0) begin
        exp_q = 16'hFFFF;
        exp_r = va[i];
      end else begin
        exp_q = va[i] / vb[i];
        exp_r = va[i] % vb[i];
      end
      issue16(3'd3, va[i], vb[i]);
      wait16(lat);
      check($sformatf("d16_lat_%0d", i), 64'(lat), 64'd5);
      check($sformatf("d16_q_%0d", i), 64'(lo16), 64'(exp_q));
      check($sformatf("d16_r_%0d", i), 64'(hi16), 64'(exp_r));
      check($sformatf("d16_dbz_%0d", i), 64'(dbz16), 64'(vb[i] == 16'd0));
      tick();
    end

    // rst overrides an operation in flight and a coincident start
    issue32(3'd1, 32'd9, 32'd9);
    tick(); tick();
    rst = 1'b1;
    start32 = 1'b1; op32 = 3'd4; opa32 = 32'h5555_5555;
    tick();
    rst = 1'b0;
    start32 = 1'b0;
    check("rst2_busy", 64'(busy32), 64'h0);
    check("rst2_hi", 64'(hi32), 64'h0);
    check("rst2_lo", 64'(lo32), 64'h0);
    check("rst2_done", 64'(done32), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
